// File: rtl/bpsk_phase_sequencer.sv
// rtl/bpsk_phase_sequencer.sv - BPSK carrier phase sequencer driving a sine table phase input
// Optional differential encoding is enabled by defining BPSK_DIFF_EN.
module bpsk_phase_sequencer #(
  parameter int DATA_WIDTH         = 16,
  parameter int SINE_RESOLUTION    = 256,
  parameter int SAMPLES_PER_SYMBOL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_valid,
  input  logic                  bit_data,
  output logic                  bit_ready,
  input  logic [DATA_WIDTH-1:0] phase_step,
  output logic [DATA_WIDTH-1:0] phase,
  output logic                  phase_valid,
  output logic                  symbol_start,
  output logic                  underrun,
  output logic                  busy
);
  localparam int CW = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam logic [DATA_WIDTH:0] PERIOD = (DATA_WIDTH+1)'(2 * SINE_RESOLUTION);
  localparam logic [DATA_WIDTH:0] HALF   = (DATA_WIDTH+1)'(SINE_RESOLUTION);
  localparam logic [CW-1:0]       LAST   = CW'(SAMPLES_PER_SYMBOL - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] step;
  logic [CW-1:0]         sample_cnt;
  logic                  inv;
  logic                  armed;
  logic                  accept;
  logic                  inv_new;
  logic [DATA_WIDTH:0]   acc_sum;
  logic [DATA_WIDTH:0]   ofs_sum;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0] phase_next;
  logic [DATA_WIDTH-1:0] step_clamped;

  // armed keeps bit_ready low while reset is held and for the cycle it is released in
  assign bit_ready = armed & ((state == IDLE) | (sample_cnt == LAST));
  assign accept    = bit_valid & bit_ready;
  assign busy      = (state == RUN);

  always_comb begin
    acc_sum      = {1'b0, acc} + {1'b0, step};
    acc_next     = DATA_WIDTH'((acc_sum >= PERIOD) ? acc_sum - PERIOD : acc_sum);
    ofs_sum      = {1'b0, acc} + (inv ? HALF : '0);
    phase_next   = DATA_WIDTH'((ofs_sum >= PERIOD) ? ofs_sum - PERIOD : ofs_sum);
    step_clamped = ({1'b0, phase_step} >= PERIOD) ? PERIOD[DATA_WIDTH-1:0] - 1'b1 : phase_step;
  end

`ifdef BPSK_DIFF_EN
  logic inv_prev;

  assign inv_new = inv_prev ^ bit_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_prev <= 1'b0;
    end else if (accept) begin
      inv_prev <= inv_new;
    end
  end
`else
  assign inv_new = bit_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      step         <= '0;
      sample_cnt   <= '0;
      inv          <= 1'b0;
      armed        <= 1'b0;
      phase        <= '0;
      phase_valid  <= 1'b0;
      symbol_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      armed        <= 1'b1;
      phase        <= '0;
      phase_valid  <= 1'b0;
      symbol_start <= 1'b0;
      // last sample still on the output while the FSM already sits in IDLE
      underrun     <= (state == IDLE) & phase_valid;
      if (accept) begin
        step <= step_clamped;
        inv  <= inv_new;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            acc        <= '0;
            sample_cnt <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          phase        <= phase_next;
          phase_valid  <= 1'b1;
          symbol_start <= (sample_cnt == '0);
          acc          <= acc_next;
          if (sample_cnt == LAST) begin
            sample_cnt <= '0;
            if (!accept) begin
              state <= IDLE;
            end
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
